srl_fifo_ctrl: RTL

Control logic for a shift-register (SRL) FIFO: drives the write-enable and read-address of an SRL storage array and presents HLS-style full_n/empty_n handshakes on both sides. Sits between a stream producer and consumer inside generated Linear_Layer kernels, for example the int4 activation/weight FIFOs. Tracks occupancy, sequences simultaneous push/pop, and optionally adds a first-word-fall-through output register.

---
 rtl/srl_fifo_pkg.sv | 7 +
 rtl/srl_fifo_storage.sv | 22 ++
 rtl/srl_fifo_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/srl_fifo_pkg.sv
// srl_fifo_pkg: shared state type and width helper for the SRL FIFO controller
package srl_fifo_pkg;
  typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} srl_state_t;
  function automatic int cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/srl_fifo_storage.sv
// srl_fifo_storage: shift-on-write register array with asynchronous read, no reset
module srl_fifo_storage #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // Shift every entry one slot deeper and insert the new word at entry 0
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  assign dout = mem[addr];
endmodule

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: SRL FIFO control with full_n/empty_n handshakes; define SRL_FIFO_OUT_REG_EN for a FWFT output register
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        if_write,
  input  logic [DATA_WIDTH-1:0]       if_din,
  output logic                        if_full_n,
  input  logic                        if_read,
  output logic [DATA_WIDTH-1:0]       if_dout,
  output logic                        if_empty_n,
  output logic [cnt_w(ADDR_WIDTH)-1:0] if_num_data_valid,
  output logic [cnt_w(ADDR_WIDTH)-1:0] if_fifo_cap
);
  localparam int CW = cnt_w(ADDR_WIDTH);
  srl_state_t state, state_d;
  logic [CW-1:0] count, count_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic push, pop, srl_pop, push_only, pop_only;
  logic [DATA_WIDTH-1:0] srl_dout;

  assign push      = if_write & if_full_n;
  assign push_only = push & ~srl_pop;
  assign pop_only  = srl_pop & ~push;

  srl_fifo_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_storage (
    .clk(clk),
    .we(push),
    .addr(addr),
    .din(if_din),
    .dout(srl_dout)
  );

`ifdef SRL_FIFO_OUT_REG_EN
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  assign pop     = if_read & out_valid;
  assign srl_pop = (count != '0) & (~out_valid | pop);
  // Output register refills from the SRL head whenever it is empty or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (srl_pop) out_data <= srl_dout;
      if (srl_pop | pop) out_valid <= srl_pop;
    end
  end
  assign if_empty_n        = out_valid;
  assign if_dout           = out_data;
  assign if_num_data_valid = count + CW'(out_valid);
  assign if_fifo_cap       = CW'(DEPTH + 1);
`else
  logic empty_n;
  assign pop     = if_read & if_empty_n;
  assign srl_pop = pop;
  // Registered non-empty flag from the occupancy about to be taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) empty_n <= 1'b0;
    else        empty_n <= count_d != '0;
  end
  assign if_empty_n        = empty_n;
  assign if_dout           = srl_dout;
  assign if_num_data_valid = count;
  assign if_fifo_cap       = CW'(DEPTH);
`endif

  // State, occupancy, read address and registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      count     <= '0;
      addr      <= '0;
      if_full_n <= 1'b1;
    end else begin
      state     <= state_d;
      count     <= count_d;
      addr      <= addr_d;
      if_full_n <= state_d != S_FULL;
    end
  end

  // Next state; a simultaneous push and pop never changes state
  always_comb begin
    state_d = state;
    case (state)
      S_EMPTY: if (push) state_d = S_PART;
      S_PART:  if (push_only && count == CW'(DEPTH - 1)) state_d = S_FULL;
               else if (pop_only && count == CW'(1)) state_d = S_EMPTY;
      S_FULL:  if (srl_pop) state_d = S_PART;
      default: state_d = S_EMPTY;
    endcase
  end

  // Occupancy and head address; addr stays 0 across the empty boundary
  always_comb begin
    count_d = push_only ? count + CW'(1) : pop_only ? count - CW'(1) : count;
    addr_d  = (push_only && state != S_EMPTY) ? addr + 1'b1 :
              (pop_only && count != CW'(1))   ? addr - 1'b1 : addr;
  end
endmodule
